// File: rtl/pc_ctrl_pkg.sv
// Shared types and PC control codes for the program-counter sequencing controller.
package pc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PUSH_HI = 3'd1,
    ST_PUSH_LO = 3'd2,
    ST_VECTOR  = 3'd3,
    ST_JUMP    = 3'd4,
    ST_POP_HI  = 3'd5,
    ST_POP_LO  = 3'd6,
    ST_RESUME  = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    KIND_CALL = 2'd0,
    KIND_INT  = 2'd1,
    KIND_RET  = 2'd2,
    KIND_RTI  = 2'd3
  } kind_e;

  localparam logic [1:0] PCSRC_INC  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_HOLD = 2'b10;
  localparam logic [1:0] INT_VEC    = 2'b11;
  localparam logic [1:0] CALL_LOAD  = 2'b11;
  localparam logic [1:0] RET_HI     = 2'b11;
  localparam logic [1:0] RET_LO     = 2'b01;

  function automatic logic is_stack_state(input state_e s);
    return (s == ST_PUSH_HI) || (s == ST_PUSH_LO) ||
           (s == ST_POP_HI)  || (s == ST_POP_LO);
  endfunction

endpackage

// File: rtl/stack_ack_timer.sv
// Wait counter for a single stack access; flags the last acceptable cycle
// without stack_ack so the controller can abandon the sequence.
module stack_ack_timer #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  input  logic ack,
  output logic timeout
);

  localparam logic [3:0] LAST_WAIT = 4'(ACK_TIMEOUT - 1);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !run) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts completed wait cycles, so this fires on the ACK_TIMEOUT-th one.
  assign timeout = run && !ack && (cnt_q == LAST_WAIT);

endmodule

// File: rtl/pc_flow_ctrl.sv
// PC sequencing controller: CALL/RET/RTI/interrupt sequences with a two-half
// stack push/pop handshake, plus branch/stall selection while idle.
module pc_flow_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       intr_req,
  input  logic       is_call,
  input  logic       is_ret,
  input  logic       is_rti,
  input  logic       br_taken,
  input  logic       hazard_stall,
  input  logic       stack_ack,
  output logic [1:0] pcSrc,
  output logic [1:0] interruptSignal,
  output logic [1:0] firstTimeCallAfterD2E,
  output logic [1:0] firstTimeRETAfterE2M,
  output logic       stack_req,
  output logic       stack_we,
  output logic       stack_half,
  output logic       intr_ack,
  output logic       flags_restore,
  output logic       flush,
  output logic       busy,
  output logic       err_timeout
);

  state_e     state_q, state_d;
  kind_e      kind_q, kind_d;
  logic       intr_pend_q, intr_pend_d;
  logic       timeout;

  logic [1:0] pc_src_q, pc_src_d;
  logic [1:0] int_sig_q, int_sig_d;
  logic [1:0] call_load_q, call_load_d;
  logic       stack_req_q, stack_req_d;
  logic       stack_we_q, stack_we_d;
  logic       stack_half_q, stack_half_d;
  logic       intr_ack_q, intr_ack_d;
  logic       flags_restore_q, flags_restore_d;
  logic       flush_q, flush_d;
  logic       busy_q, busy_d;
  logic       err_timeout_q, err_timeout_d;

  stack_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (state_d != state_q),
    .run     (is_stack_state(state_q)),
    .ack     (stack_ack),
    .timeout (timeout)
  );

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    intr_pend_d   = intr_pend_q | intr_req;
    err_timeout_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (intr_pend_q) begin
          state_d = ST_PUSH_HI;
          kind_d  = KIND_INT;
        end else if (is_call) begin
          state_d = ST_PUSH_HI;
          kind_d  = KIND_CALL;
        end else if (is_rti) begin
          state_d = ST_POP_HI;
          kind_d  = KIND_RTI;
        end else if (is_ret) begin
          state_d = ST_POP_HI;
          kind_d  = KIND_RET;
        end
      end
      ST_PUSH_HI: if (stack_ack) state_d = ST_PUSH_LO;
      ST_PUSH_LO: if (stack_ack) state_d = (kind_q == KIND_INT) ? ST_VECTOR : ST_JUMP;
      ST_VECTOR: begin
        state_d     = ST_IDLE;
        intr_pend_d = 1'b0;
      end
      ST_JUMP:    state_d = ST_IDLE;
      ST_POP_HI:  if (stack_ack) state_d = ST_POP_LO;
      ST_POP_LO:  if (stack_ack) state_d = ST_RESUME;
      ST_RESUME:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Abandon the sequence; a pending interrupt survives and is retried from IDLE.
    if (timeout) begin
      state_d       = ST_IDLE;
      kind_d        = KIND_CALL;
      err_timeout_d = 1'b1;
    end
  end

  // Moore outputs are registered by decoding the next state.
  always_comb begin
    pc_src_d        = PCSRC_INC;
    int_sig_d       = 2'b00;
    call_load_d     = 2'b00;
    stack_req_d     = 1'b0;
    stack_we_d      = 1'b0;
    stack_half_d    = 1'b0;
    intr_ack_d      = 1'b0;
    flags_restore_d = 1'b0;
    flush_d         = 1'b0;
    busy_d          = 1'b0;

    if (state_d != ST_IDLE) begin
      pc_src_d = PCSRC_HOLD;
      flush_d  = 1'b1;
      busy_d   = 1'b1;
    end else if (state_q == ST_IDLE) begin
      if (br_taken) begin
        pc_src_d = PCSRC_BR;
      end else if (hazard_stall) begin
        pc_src_d = PCSRC_HOLD;
      end
    end

    unique case (state_d)
      ST_PUSH_HI: begin
        stack_req_d  = 1'b1;
        stack_we_d   = 1'b1;
        stack_half_d = 1'b1;
      end
      ST_PUSH_LO: begin
        stack_req_d = 1'b1;
        stack_we_d  = 1'b1;
      end
      ST_VECTOR: begin
        int_sig_d  = INT_VEC;
        intr_ack_d = 1'b1;
      end
      ST_JUMP: call_load_d = CALL_LOAD;
      ST_POP_HI: begin
        stack_req_d  = 1'b1;
        stack_half_d = 1'b1;
      end
      ST_POP_LO: stack_req_d = 1'b1;
      ST_RESUME: flags_restore_d = (kind_d == KIND_RTI);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      kind_q          <= KIND_CALL;
      intr_pend_q     <= 1'b0;
      pc_src_q        <= PCSRC_INC;
      int_sig_q       <= 2'b00;
      call_load_q     <= 2'b00;
      stack_req_q     <= 1'b0;
      stack_we_q      <= 1'b0;
      stack_half_q    <= 1'b0;
      intr_ack_q      <= 1'b0;
      flags_restore_q <= 1'b0;
      flush_q         <= 1'b0;
      busy_q          <= 1'b0;
      err_timeout_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      kind_q          <= kind_d;
      intr_pend_q     <= intr_pend_d;
      pc_src_q        <= pc_src_d;
      int_sig_q       <= int_sig_d;
      call_load_q     <= call_load_d;
      stack_req_q     <= stack_req_d;
      stack_we_q      <= stack_we_d;
      stack_half_q    <= stack_half_d;
      intr_ack_q      <= intr_ack_d;
      flags_restore_q <= flags_restore_d;
      flush_q         <= flush_d;
      busy_q          <= busy_d;
      err_timeout_q   <= err_timeout_d;
    end
  end

  // Pop load codes are valid only in the cycle the memory returns data.
  always_comb begin
    firstTimeRETAfterE2M = 2'b00;
    if (stack_ack) begin
      if (state_q == ST_POP_HI) begin
        firstTimeRETAfterE2M = RET_HI;
      end else if (state_q == ST_POP_LO) begin
        firstTimeRETAfterE2M = RET_LO;
      end
    end
  end

  assign pcSrc                 = pc_src_q;
  assign interruptSignal       = int_sig_q;
  assign firstTimeCallAfterD2E = call_load_q;
  assign stack_req             = stack_req_q;
  assign stack_we              = stack_we_q;
  assign stack_half            = stack_half_q;
  assign intr_ack              = intr_ack_q;
  assign flags_restore         = flags_restore_q;
  assign flush                 = flush_q;
  assign busy                  = busy_q;
  assign err_timeout           = err_timeout_q;

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Directed bench for pc_flow_ctrl: every output packed into one vector and
// compared against hand-built expected patterns each cycle.
module tb_pc_flow_ctrl;

  logic       clk = 1'b0;
  logic       reset, intr_req, is_call, is_ret, is_rti, br_taken, hazard_stall, stack_ack;
  logic [1:0] pcSrc, interruptSignal, firstTimeCallAfterD2E, firstTimeRETAfterE2M;
  logic       stack_req, stack_we, stack_half, intr_ack, flags_restore, flush, busy, err_timeout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pc_flow_ctrl #(
    .ACK_TIMEOUT(15)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .intr_req              (intr_req),
    .is_call               (is_call),
    .is_ret                (is_ret),
    .is_rti                (is_rti),
    .br_taken              (br_taken),
    .hazard_stall          (hazard_stall),
    .stack_ack             (stack_ack),
    .pcSrc                 (pcSrc),
    .interruptSignal       (interruptSignal),
    .firstTimeCallAfterD2E (firstTimeCallAfterD2E),
    .firstTimeRETAfterE2M  (firstTimeRETAfterE2M),
    .stack_req             (stack_req),
    .stack_we              (stack_we),
    .stack_half            (stack_half),
    .intr_ack              (intr_ack),
    .flags_restore         (flags_restore),
    .flush                 (flush),
    .busy                  (busy),
    .err_timeout           (err_timeout)
  );

  // {pcSrc, interruptSignal, call, ret, req, we, half, iack, flags, flush, busy, err}
  logic [15:0] obs;
  assign obs = {pcSrc, interruptSignal, firstTimeCallAfterD2E, firstTimeRETAfterE2M,
                stack_req, stack_we, stack_half, intr_ack, flags_restore, flush, busy, err_timeout};

  localparam logic [15:0] O_IDLE     = {2'b00, 2'b00, 2'b00, 2'b00, 8'b0000_0000};
  localparam logic [15:0] O_BR       = {2'b01, 2'b00, 2'b00, 2'b00, 8'b0000_0000};
  localparam logic [15:0] O_STALL    = {2'b10, 2'b00, 2'b00, 2'b00, 8'b0000_0000};
  localparam logic [15:0] O_ERR      = {2'b00, 2'b00, 2'b00, 2'b00, 8'b0000_0001};
  localparam logic [15:0] O_PUSH_HI  = {2'b10, 2'b00, 2'b00, 2'b00, 8'b1110_0110};
  localparam logic [15:0] O_PUSH_LO  = {2'b10, 2'b00, 2'b00, 2'b00, 8'b1100_0110};
  localparam logic [15:0] O_JUMP     = {2'b10, 2'b00, 2'b11, 2'b00, 8'b0000_0110};
  localparam logic [15:0] O_VECTOR   = {2'b10, 2'b11, 2'b00, 2'b00, 8'b0001_0110};
  localparam logic [15:0] O_POP_HI   = {2'b10, 2'b00, 2'b00, 2'b00, 8'b1010_0110};
  localparam logic [15:0] O_POP_HI_A = {2'b10, 2'b00, 2'b00, 2'b11, 8'b1010_0110};
  localparam logic [15:0] O_POP_LO   = {2'b10, 2'b00, 2'b00, 2'b00, 8'b1000_0110};
  localparam logic [15:0] O_POP_LO_A = {2'b10, 2'b00, 2'b00, 2'b01, 8'b1000_0110};
  localparam logic [15:0] O_RESUME   = {2'b10, 2'b00, 2'b00, 2'b00, 8'b0000_0110};
  localparam logic [15:0] O_RES_RTI  = {2'b10, 2'b00, 2'b00, 2'b00, 8'b0000_1110};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ack(input logic v);
    stack_ack = v;
    #1;
  endtask

  initial begin
    reset = 1'b0; intr_req = 1'b0; is_call = 1'b0; is_ret = 1'b0; is_rti = 1'b0;
    br_taken = 1'b0; hazard_stall = 1'b0; stack_ack = 1'b0;
    tick(); tick();
    check("reset", obs, O_IDLE);
    reset = 1'b1;
    tick();
    check("idle", obs, O_IDLE);

    // CALL with ack held high
    is_call = 1'b1; stack_ack = 1'b1;
    tick(); is_call = 1'b0;
    check("call_push_hi", obs, O_PUSH_HI);
    tick(); check("call_push_lo", obs, O_PUSH_LO);
    tick(); check("call_jump", obs, O_JUMP);
    tick(); check("call_done", obs, O_IDLE);
    set_ack(1'b0);

    // RET with two wait cycles in each half
    is_ret = 1'b1;
    tick(); is_ret = 1'b0;
    check("ret_hi_w0", obs, O_POP_HI);
    tick(); check("ret_hi_w1", obs, O_POP_HI);
    tick(); check("ret_hi_w2", obs, O_POP_HI);
    set_ack(1'b1); check("ret_hi_ack", obs, O_POP_HI_A);
    tick(); set_ack(1'b0);
    check("ret_lo_w0", obs, O_POP_LO);
    tick(); check("ret_lo_w1", obs, O_POP_LO);
    tick(); check("ret_lo_w2", obs, O_POP_LO);
    set_ack(1'b1); check("ret_lo_ack", obs, O_POP_LO_A);
    tick(); set_ack(1'b0);
    check("ret_resume", obs, O_RESUME);
    tick(); check("ret_done", obs, O_IDLE);

    // interrupt raised during a CALL waits for IDLE
    is_call = 1'b1; stack_ack = 1'b1;
    tick(); is_call = 1'b0; intr_req = 1'b1;
    check("ic_push_hi", obs, O_PUSH_HI);
    tick(); intr_req = 1'b0;
    check("ic_push_lo", obs, O_PUSH_LO);
    tick(); check("ic_jump", obs, O_JUMP);
    tick(); check("ic_idle", obs, O_IDLE);
    tick(); check("int_push_hi", obs, O_PUSH_HI);
    tick(); check("int_push_lo", obs, O_PUSH_LO);
    tick(); check("int_vector", obs, O_VECTOR);
    tick(); check("int_done", obs, O_IDLE);
    tick(); check("int_no_retake", obs, O_IDLE);

    // RTI with immediate ack
    is_rti = 1'b1;
    tick(); is_rti = 1'b0;
    check("rti_hi_ack", obs, O_POP_HI_A);
    tick(); check("rti_lo_ack", obs, O_POP_LO_A);
    tick(); set_ack(1'b0);
    check("rti_resume", obs, O_RES_RTI);
    tick(); check("rti_done", obs, O_IDLE);

    // push timeout: 15 cycles in PUSH_HI without ack
    is_call = 1'b1;
    tick(); is_call = 1'b0;
    check("to_enter", obs, O_PUSH_HI);
    for (int i = 0; i < 14; i++) begin
      tick(); check("to_wait", obs, O_PUSH_HI);
    end
    tick(); check("to_err", obs, O_ERR);
    tick(); check("to_err_clear", obs, O_IDLE);

    // branch / stall selection in IDLE
    br_taken = 1'b1;
    tick(); check("branch", obs, O_BR);
    hazard_stall = 1'b1;
    tick(); check("branch_over_stall", obs, O_BR);
    br_taken = 1'b0;
    tick(); check("stall", obs, O_STALL);
    hazard_stall = 1'b0;
    tick(); check("plus_one", obs, O_IDLE);

    // reset while in POP_LO
    is_ret = 1'b1; stack_ack = 1'b1;
    tick(); is_ret = 1'b0;
    tick(); set_ack(1'b0);
    check("rst_pop_lo", obs, O_POP_LO);
    reset = 1'b0;
    tick(); check("rst_mid", obs, O_IDLE);
    reset = 1'b1; br_taken = 1'b1;
    tick(); check("post_rst_br", obs, O_BR);
    br_taken = 1'b0;
    tick(); check("post_rst_idle", obs, O_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
